// File: rtl/iter_multiplier_if.sv
// Operand/result handshake bundle for iter_multiplier.
// The master drives operands and out_ready; the slave (the multiplier) returns status and P.
interface iter_multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] P;
  logic               busy;

  modport master (
    output in_valid, A, B, signed_mode, out_ready,
    input  in_ready, out_valid, P, busy
  );

  modport slave (
    input  in_valid, A, B, signed_mode, out_ready,
    output in_ready, out_valid, P, busy
  );
endinterface

// File: rtl/iter_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per clock, unsigned or two's-complement.
// Works on operand magnitudes and applies the result sign once the last iteration completes.
module iter_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  iter_multiplier_if.slave bus
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    addend, acc_sum;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is the right unsigned magnitude.
  assign mag_a = (bus.signed_mode && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign mag_b = (bus.signed_mode && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  assign addend  = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
  assign acc_sum = acc_q + addend;

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sign_d   = bus.signed_mode & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
          mcand_d  = mag_a;
          mplier_d = mag_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          // A zero magnitude negates to zero, so no -0 special case is needed.
          p_d     = sign_q ? -acc_sum : acc_sum;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.P         = p_q;
endmodule
